// File: rtl/wb_stage.sv
// wb_stage: RV32I writeback stage with load wait, load alignment and registered register-file write.
// Optional bypass outputs FwdValid/FwdRd/FwdData are generated when WB_FWD_EN is defined.
module wb_stage #(
   parameter int LOAD_TIMEOUT = 15
) (
   input  logic        WrClk,
   input  logic        Reset,
   input  logic        InValid,
   output logic        InReady,
   input  logic [4:0]  InRd,
   input  logic        InRegWr,
   input  logic [1:0]  InSel,
   input  logic [31:0] InAluRes,
   input  logic [31:0] InPc4,
   input  logic [31:0] InImm,
   input  logic [2:0]  InFunct3,
   input  logic        MemAck,
   input  logic [31:0] MemRdata,
   output logic [4:0]  Rw,
   output logic [31:0] busW,
   output logic        RegWr,
   output logic        LoadErr
`ifdef WB_FWD_EN
   ,
   output logic        FwdValid,
   output logic [4:0]  FwdRd,
   output logic [31:0] FwdData
`endif
);
   typedef enum logic [1:0] {IDLE, WAIT, WRITE, ERR} state_t;
   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [4:0]  rd_q, rd_d, rw_q, rw_d;
   logic        wr_q, wr_d, regwr_q, regwr_d, lerr_q, lerr_d;
   logic [2:0]  f3_q, f3_d;
   logic [1:0]  a_q, a_d;
   logic [31:0] busw_q, busw_d, ld;
   logic [7:0]  b;
   logic [15:0] h;
   logic        bad;
   logic        unused_addr;

   assign unused_addr = ^InAluRes[31:2];
   assign InReady = state_q != WAIT;
   assign Rw      = rw_q;
   assign busW    = busw_q;
   assign RegWr   = regwr_q;
   assign LoadErr = lerr_q;
`ifdef WB_FWD_EN
   assign FwdValid = regwr_q;
   assign FwdRd    = rd_q;
   assign FwdData  = busw_q;
`endif

   assign b   = MemRdata[{a_q, 3'b000} +: 8];
   assign h   = MemRdata[{a_q[1], 4'b0000} +: 16];
   assign ld  = f3_q[1:0] == 2'b00 ? {{24{b[7] & ~f3_q[2]}}, b} :
                f3_q[1:0] == 2'b01 ? {{16{h[15] & ~f3_q[2]}}, h} : MemRdata;
   assign bad = InFunct3 == 3'b011 || InFunct3[2:1] == 2'b11 ||
                (InFunct3[1:0] == 2'b01 && InAluRes[0]) ||
                (InFunct3 == 3'b010 && InAluRes[1:0] != 2'b00);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      f3_d    = f3_q;
      a_d     = a_q;
      rw_d    = rw_q;
      busw_d  = busw_q;
      regwr_d = 1'b0;
      lerr_d  = 1'b0;
      if (state_q == WAIT) begin
         if (MemAck) begin
            state_d = WRITE;
            rw_d    = rd_q;
            busw_d  = ld;
            regwr_d = wr_q && rd_q != 5'd0;
         end else if (cnt_q == 8'(LOAD_TIMEOUT - 1)) begin
            state_d = ERR;
            lerr_d  = 1'b1;
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
      end else begin
         state_d = IDLE;
         if (InValid) begin
            rd_d  = InRd;
            wr_d  = InRegWr;
            f3_d  = InFunct3;
            a_d   = InAluRes[1:0];
            cnt_d = 8'd0;
            if (InSel != 2'b01) begin
               state_d = WRITE;
               rw_d    = InRd;
               busw_d  = InSel == 2'b00 ? InAluRes : InSel == 2'b10 ? InPc4 : InImm;
               regwr_d = InRegWr && InRd != 5'd0;
            end else if (bad) begin
               state_d = ERR;
               lerr_d  = 1'b1;
            end else begin
               state_d = WAIT;
            end
         end
      end
   end

   always_ff @(posedge WrClk) begin
      if (Reset) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
         rd_q    <= 5'd0;
         wr_q    <= 1'b0;
         f3_q    <= 3'd0;
         a_q     <= 2'd0;
         rw_q    <= 5'd0;
         busw_q  <= 32'd0;
         regwr_q <= 1'b0;
         lerr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         f3_q    <= f3_d;
         a_q     <= a_d;
         rw_q    <= rw_d;
         busw_q  <= busw_d;
         regwr_q <= regwr_d;
         lerr_q  <= lerr_d;
      end
   end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: randomized self-checking bench for wb_stage against a transaction-level model.
module tb_wb_stage;
   localparam int T = 15;
   logic        WrClk = 1'b0;
   logic        Reset, InValid, InRegWr, MemAck, InReady, RegWr, LoadErr;
   logic [4:0]  InRd, Rw;
   logic [1:0]  InSel;
   logic [2:0]  InFunct3;
   logic [31:0] InAluRes, InPc4, InImm, MemRdata, busW;
`ifdef WB_FWD_EN
   logic        FwdValid;
   logic [4:0]  FwdRd;
   logic [31:0] FwdData;
`endif
   logic [31:0] rf [32];
   int tests = 0;
   int fails = 0;

   wb_stage #(.LOAD_TIMEOUT(T)) dut (
      .WrClk(WrClk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
      .InRd(InRd), .InRegWr(InRegWr), .InSel(InSel), .InAluRes(InAluRes),
      .InPc4(InPc4), .InImm(InImm), .InFunct3(InFunct3), .MemAck(MemAck),
      .MemRdata(MemRdata), .Rw(Rw), .busW(busW), .RegWr(RegWr), .LoadErr(LoadErr)
`ifdef WB_FWD_EN
      , .FwdValid(FwdValid), .FwdRd(FwdRd), .FwdData(FwdData)
`endif
   );

   always #5 WrClk = ~WrClk;

   always @(negedge WrClk) if (RegWr === 1'b1) rf[Rw] <= busW;

   task automatic step();
      @(posedge WrClk);
      #1;
   endtask

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w);
      logic [31:0] s;
      s = f3[0] ? w >> (int'(a[1]) * 16) : w >> (int'(a) * 8);
      case (f3)
         3'd0:    return 32'($signed(s[7:0]));
         3'd4:    return {24'd0, s[7:0]};
         3'd1:    return 32'($signed(s[15:0]));
         3'd5:    return {16'd0, s[15:0]};
         default: return w;
      endcase
   endfunction

   function automatic bit ref_bad(input logic [2:0] f3, input logic [1:0] a);
      return f3 == 3 || f3 == 6 || f3 == 7 || ((f3 == 1 || f3 == 5) && a[0]) || (f3 == 2 && a != 0);
   endfunction

   task automatic run_txn(input logic [4:0] rd, input logic wr, input logic [1:0] sel,
                          input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] imm,
                          input logic [31:0] rdata, input logic [2:0] f3, input int delay, input logic early_ack);
      logic [31:0] exp;
      logic exp_wr, is_err;
      tests++;
      if (InReady !== 1'b1) begin fails++; $display("FAIL ready_pre got %b want 1", InReady); end
      InValid = 1; InRd = rd; InRegWr = wr; InSel = sel; InAluRes = alu; InPc4 = pc4;
      InImm = imm; InFunct3 = f3; MemAck = early_ack; MemRdata = ~rdata;
      step();
      InValid = 0; MemAck = 0;
      exp_wr = wr && rd != 0;
      is_err = 0;
      exp = 32'd0;
      if (sel != 2'b01) begin
         exp = sel == 0 ? alu : sel == 2 ? pc4 : imm;
      end else if (ref_bad(f3, alu[1:0])) begin
         is_err = 1;
      end else begin
         for (int i = 1; i < delay && i <= T; i++) begin
            tests++;
            if ({InReady, LoadErr, RegWr} !== 3'b000) begin
               fails++; $display("FAIL wait_state cyc %0d got rdy/err/wr %b want 000", i, {InReady, LoadErr, RegWr});
            end
`ifdef WB_FWD_EN
            tests++;
            if (FwdRd !== rd) begin fails++; $display("FAIL fwd_rd_wait got %0d want %0d", FwdRd, rd); end
`endif
            step();
         end
         if (delay <= T) begin
            tests++;
            if (InReady !== 1'b0) begin fails++; $display("FAIL ready_wait got %b want 0", InReady); end
            MemAck = 1; MemRdata = rdata;
            step();
            MemAck = 0;
            exp = ref_load(f3, alu[1:0], rdata);
         end else begin
            is_err = 1;
         end
      end
      tests++;
      if ({RegWr, LoadErr} !== {exp_wr && !is_err, is_err}) begin
         fails++; $display("FAIL result_kind got wr/err %b want %b", {RegWr, LoadErr}, {exp_wr && !is_err, is_err});
      end
      if (exp_wr && !is_err) begin
         tests++;
         if ({Rw, busW} !== {rd, exp}) begin
            fails++; $display("FAIL write_data got rw=%0d busw=%h want rw=%0d busw=%h", Rw, busW, rd, exp);
         end
`ifdef WB_FWD_EN
         tests++;
         if ({FwdValid, FwdRd, FwdData} !== {1'b1, rd, exp}) begin
            fails++; $display("FAIL fwd_write got %b/%0d/%h want 1/%0d/%h", FwdValid, FwdRd, FwdData, rd, exp);
         end
`endif
      end
   endtask

   task automatic test_reset();
      Reset = 1; InValid = 0; MemAck = 0;
      step();
      step();
      tests++;
      if ({InReady, RegWr, LoadErr, Rw, busW} !== {3'b100, 5'd0, 32'd0}) begin
         fails++; $display("FAIL reset got rdy/wr/err=%b rw=%0d busw=%h want 100/0/0", {InReady, RegWr, LoadErr}, Rw, busW);
      end
`ifdef WB_FWD_EN
      tests++;
      if ({FwdValid, FwdRd, FwdData} !== 38'd0) begin fails++; $display("FAIL reset_fwd got %b/%0d/%h want 0", FwdValid, FwdRd, FwdData); end
`endif
      Reset = 0;
   endtask

   task automatic test_alu();
      run_txn(5'd5, 1, 2'b00, 32'h1234_5678, 32'h4, 32'h0, 32'h0, 3'd0, 1, 0);
      step();
      tests++;
      if (rf[5] !== 32'h1234_5678) begin fails++; $display("FAIL rf_x5 got %h want 12345678", rf[5]); end
   endtask

   task automatic test_load_ext();
      run_txn(5'd7, 1, 2'b01, 32'h0000_1003, 32'h0, 32'h0, 32'h80FF_0000, 3'd0, 2, 1);
      tests++;
      if (busW !== 32'hFFFF_FF80) begin fails++; $display("FAIL lb_sext got %h want ffffff80", busW); end
      run_txn(5'd7, 1, 2'b01, 32'h0000_1003, 32'h0, 32'h0, 32'h80FF_0000, 3'd4, 2, 0);
      tests++;
      if (busW !== 32'h0000_0080) begin fails++; $display("FAIL lbu_zext got %h want 00000080", busW); end
   endtask

   task automatic test_x0_and_misalign();
      run_txn(5'd0, 1, 2'b01, 32'h0000_2000, 32'h0, 32'h0, 32'hDEAD_BEEF, 3'd2, 1, 0);
      run_txn(5'd4, 1, 2'b01, 32'h0000_2001, 32'h0, 32'h0, 32'h0, 3'd1, 1, 0);
      run_txn(5'd4, 0, 2'b01, 32'h0000_2002, 32'h0, 32'h0, 32'hCAFE_F00D, 3'd5, 3, 0);
      run_txn(5'd6, 1, 2'b01, 32'h0000_2000, 32'h0, 32'h0, 32'h0, 3'd6, 1, 0);
   endtask

   task automatic test_timeout();
      run_txn(5'd8, 1, 2'b01, 32'h0000_3000, 32'h0, 32'h0, 32'h1111_2222, 3'd2, T + 1, 0);
      MemAck = 1; MemRdata = 32'h5555_AAAA;
      step();
      MemAck = 0;
      tests++;
      if ({InReady, RegWr, LoadErr} !== 3'b100) begin
         fails++; $display("FAIL late_ack got rdy/wr/err %b want 100", {InReady, RegWr, LoadErr});
      end
   endtask

   task automatic test_reset_wait();
      InValid = 1; InRd = 5'd9; InRegWr = 1; InSel = 2'b01; InAluRes = 32'h0; InFunct3 = 3'd2;
      step();
      InValid = 0;
      step();
      step();
      Reset = 1;
      step();
      Reset = 0;
      tests++;
      if ({InReady, RegWr, LoadErr} !== 3'b100) begin
         fails++; $display("FAIL reset_wait got rdy/wr/err %b want 100", {InReady, RegWr, LoadErr});
      end
      MemAck = 1; MemRdata = 32'h7777_7777;
      step();
      MemAck = 0;
      tests++;
      if ({RegWr, LoadErr} !== 2'b00) begin fails++; $display("FAIL ack_after_reset got wr/err %b want 00", {RegWr, LoadErr}); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d [3];
      for (int i = 0; i < 3; i++) d[i] = $urandom;
      for (int i = 0; i < 3; i++) run_txn(5'(i + 1), 1, 2'b00, d[i], 32'h0, 32'h0, 32'h0, 3'd0, 1, 0);
      step();
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (rf[i + 1] !== d[i]) begin fails++; $display("FAIL rf_b2b x%0d got %h want %h", i + 1, rf[i + 1], d[i]); end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 60; n++) begin
         logic [1:0] sel;
         sel = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'($urandom_range(0, 3));
         run_txn(5'($urandom), 1'($urandom), sel, $urandom, $urandom, $urandom, $urandom,
                 3'($urandom), ($urandom_range(0, 5) == 0) ? T + 1 : $urandom_range(1, 4), 1'($urandom));
         if ($urandom_range(0, 3) == 0) step();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = 32'd0;
      InValid = 0; InRd = 0; InRegWr = 0; InSel = 0; InAluRes = 0; InPc4 = 0;
      InImm = 0; InFunct3 = 0; MemAck = 0; MemRdata = 0; Reset = 1;
      test_reset();
      test_alu();
      test_reset();
      test_load_ext();
      test_x0_and_misalign();
      test_timeout();
      test_reset_wait();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the RV32I pipeline, sitting directly upstream of the register file's write port. It accepts one retiring instruction at a time from the memory stage and waits for data-memory acknowledge on loads. It aligns and extends load data, selects the result source, and drives `Rw`/`busW`/`RegWr` as registered outputs. The register file commits them on the falling edge of the same cycle.

## Interface
- `LOAD_TIMEOUT`, 15: maximum WAIT cycles without `MemAck` before a load is abandoned (1..255).
- `WrClk` in 1: shared CPU clock; this block uses rising edge only.
- `Reset` in 1: synchronous, active-high.
- `InValid` in 1: memory stage presents an instruction.
- `InReady` out 1: stage can accept this cycle.
- `InRd` in 5: destination register.
- `InRegWr` in 1: instruction writes a register.
- `InSel` in 2: result source. 00 ALU, 01 load, 10 PC+4, 11 immediate (LUI).
- `InAluRes` in 32: ALU result. On loads, byte address; only bits [1:0] are used.
- `InPc4` in 32: PC+4.
- `InImm` in 32: U-immediate.
- `InFunct3` in 3: load type.
- `MemAck` in 1: data memory read data valid.
- `MemRdata` in 32: raw aligned word from data memory.
- `Rw` out 5: register-file write address.
- `busW` out 32: register-file write data.
- `RegWr` out 1: register-file write enable, one-cycle pulse.
- `LoadErr` out 1: one-cycle pulse for illegal, misaligned or timed-out load.
- `FwdValid` out 1, `FwdRd` out 5, `FwdData` out 32: bypass outputs; present only with `WB_FWD_EN`.

## Operation
- States: IDLE, WAIT, WRITE, ERR.
- `InReady` is 1 in IDLE, WRITE and ERR, and 0 in WAIT.
- Handshake: a transfer occurs on a rising edge with `InValid && InReady`.
- Accepted non-load (`InSel != 01`): result is captured and the state goes to WRITE.
- Accepted legal load: the state goes to WAIT and the cycle counter clears to 0.
- Illegal or misaligned load: the state goes to ERR and no memory wait occurs.
  - Illegal `InFunct3`: 011, 110, 111.
  - Misaligned: LH/LHU with addr[0]=1, or LW with addr[1:0]!=0.
- WAIT, `MemAck` sampled 1: the aligned word is captured and the state goes to WRITE.
- WAIT, `MemAck` sampled 0: the counter increments. When the count reaches `LOAD_TIMEOUT`, the state goes to ERR.
- `MemAck` is ignored outside WAIT, including during the acceptance cycle.
- WRITE / ERR: last for one cycle. Next state is IDLE, or the next accepted instruction's state if a transfer happens.
- Load alignment:
  - LB/LBU (000/100): byte `addr[1:0]`, sign- or zero-extended.
  - LH/LHU (001/101): halfword `addr[1]`, sign- or zero-extended.
  - LW (010): full word.
- `RegWr` is 1 only in WRITE, and only when `InRegWr` was 1 and `InRd != 0`. A write to x0 is suppressed here.
- An instruction with `InRegWr` = 0 still completes normally, including the load wait.
- `LoadErr` is 1 only in ERR; `RegWr` is 0 in ERR.
- Reset values: state IDLE, `Rw` 0, `busW` 0, `RegWr` 0, `LoadErr` 0, `InReady` 1, `FwdValid` 0, `FwdRd` 0, `FwdData` 0.
- Reset during WAIT drops the load. A late `MemAck` afterwards is ignored.

## Timing
- Non-load accepted at rising edge N: `RegWr`/`Rw`/`busW` are valid in cycle N+1 (after edge N). The register file writes at the falling edge inside cycle N+1.
- Load accepted at edge N with `MemAck` high during cycle N+k (k≥1): the write is valid in cycle N+k+1.
- Timeout: `LoadErr` is high in cycle N+`LOAD_TIMEOUT`+1.
- Back-to-back non-loads: throughput of one per cycle.
- Outputs are fully registered; there are no combinational paths from inputs to outputs except to `InReady`, which depends on state only.

## Configuration
- `WB_FWD_EN` defined:
  - In WAIT and WRITE, `FwdRd` holds the pending `Rd`.
  - `FwdValid` is 1 in WRITE when `RegWr` is 1.
  - `FwdData` equals `busW`.
  - Decode uses these outputs to bypass reads that occur in the first half-cycle, before the falling-edge write.
- `WB_FWD_EN` undefined: the three bypass ports are absent, and no forwarding logic is generated.

## Test plan
- Reset, then ALU op with `InRd`=5, `InAluRes`=0x1234_5678 → next cycle `RegWr`=1, `Rw`=5, `busW`=0x1234_5678; register-file x5 reads 0x1234_5678 afterwards.
- LB with addr=0x...03, `MemAck` 2 cycles later with `MemRdata`=0x80FF_0000 → `busW`=0xFFFF_FF80. The same sequence as LBU → `busW`=0x0000_0080.
- LW to `InRd`=0 with ack → `RegWr`=0 and no `LoadErr`. LH with addr[0]=1 → `LoadErr` pulse next cycle, `RegWr` stays 0.
- Load with no `MemAck` → `LoadErr` exactly `LOAD_TIMEOUT`+1 cycles after acceptance, `InReady` 0 throughout WAIT. A `MemAck` one cycle later is ignored.
- `Reset` asserted mid-WAIT, then `MemAck` → no write; `InReady`=1 the cycle after reset.
- Three back-to-back ALU ops to x1, x2, x3 → three consecutive `RegWr` pulses with matching data. With `WB_FWD_EN`, `FwdRd`/`FwdData` track each write.
